dm_bytelane: RTL and testbench

Parametrised data memory for the single-cycle/multi-cycle MIPS datapath, succeeding the fixed 1K-word memory. Adds byte addressing with byte/half/word stores and sign- or zero-extended loads (sb/sh/sw, lb/lbu/lh/lhu/lw), and a configurable wait-state latency behind a req/ack handshake. Sits between the ALU address output and the register-file write-back mux. A one-cycle error pulse reports misaligned or illegal accesses.

---
 rtl/dm_bytelane.sv | 178 +++++++++++++++++
 tb/tb_dm_bytelane.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/dm_bytelane.sv
// Byte-addressable data memory with sub-word stores, sign/zero-extended loads
// and a programmable wait-state count in front of each access.
module dm_bytelane #(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [1:0]            i_size,
    input  logic                  i_uns,
    input  logic [31:0]           i_din,
    output logic [31:0]           o_dout,
    output logic                  o_ack,
    output logic                  o_err,
    output logic                  o_busy,
    output logic [1:0]            o_state
);

    localparam int DEPTH = 1 << (ADDR_WIDTH - 2);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [3:0] LAT = 4'(LATENCY);

    logic [1:0]            r_state;
    logic [3:0]            r_cnt;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [1:0]            r_size;
    logic                  r_uns;
    logic [31:0]           r_din;
    logic [31:0]           r_dout;
    logic                  r_ack;
    logic                  r_err;
    logic [31:0]           r_rdata;
    logic [31:0]           r_mem [DEPTH];

    logic                  w_bad;
    logic [ADDR_WIDTH-3:0] w_rd_idx;
    logic [ADDR_WIDTH-3:0] w_wr_idx;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_load;

    // Misaligned halves/words and the reserved size code are rejected.
    always_comb begin
        w_bad = 1'b0;
        case (r_size)
            2'b01:   w_bad = r_addr[0];
            2'b10:   w_bad = (r_addr[1:0] != 2'b00);
            2'b11:   w_bad = 1'b1;
            default: w_bad = 1'b0;
        endcase
    end

    // The read port runs every cycle; in IDLE it follows the live address so
    // the word is already registered when a zero-latency request hits ACCESS.
    assign w_rd_idx = (r_state == S_IDLE) ? i_addr[ADDR_WIDTH-1:2] : r_addr[ADDR_WIDTH-1:2];
    assign w_wr_idx = r_addr[ADDR_WIDTH-1:2];

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = r_din;
        case (r_size)
            2'b00: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_wdata = {4{r_din[7:0]}};
            end
            2'b01: begin
                w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{r_din[15:0]}};
            end
            2'b10: begin
                w_be    = 4'b1111;
                w_wdata = r_din;
            end
            default: begin
                w_be    = 4'b0000;
                w_wdata = r_din;
            end
        endcase
        if (!(r_state == S_ACCESS && r_we && !w_bad)) begin
            w_be = 4'b0000;
        end
    end

    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (w_be[b]) begin
                r_mem[w_wr_idx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
        end
        r_rdata <= r_mem[w_rd_idx];
    end

    always_comb begin
        w_byte = r_rdata[7:0];
        case (r_addr[1:0])
            2'd0:    w_byte = r_rdata[7:0];
            2'd1:    w_byte = r_rdata[15:8];
            2'd2:    w_byte = r_rdata[23:16];
            default: w_byte = r_rdata[31:24];
        endcase
        w_half = r_addr[1] ? r_rdata[31:16] : r_rdata[15:0];
        case (r_size)
            2'b00:   w_load = r_uns ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load = r_uns ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load = r_rdata;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_size  <= 2'b00;
            r_uns   <= 1'b0;
            r_din   <= 32'd0;
            r_dout  <= 32'd0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_req) begin
                        r_we   <= i_we;
                        r_addr <= i_addr;
                        r_size <= i_size;
                        r_uns  <= i_uns;
                        r_din  <= i_din;
                        if (LAT == 4'd0) begin
                            r_state <= S_ACCESS;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= LAT;
                        end
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_state <= S_RESP;
                    r_ack   <= 1'b1;
                    r_err   <= w_bad;
                    if (!r_we && !w_bad) begin
                        r_dout <= w_load;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_dout  = r_dout;
    assign o_ack   = r_ack;
    assign o_err   = r_err;
    assign o_busy  = (r_state != S_IDLE);
    assign o_state = r_state;

endmodule

// File: tb/tb_dm_bytelane.sv
// Directed bench for dm_bytelane: LATENCY=1 functional checks, plus
// LATENCY=0/5 instances sharing the inputs for handshake timing.
module tb_dm_bytelane;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [11:0] addr = 12'd0;
    logic [1:0]  size = 2'b10;
    logic        uns = 1'b0;
    logic [31:0] din = 32'd0;

    logic [31:0] dout [3];
    logic        ack [3];
    logic        err [3];
    logic        busy [3];
    logic [1:0]  state [3];

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    // index 0: LATENCY=1, index 1: LATENCY=0, index 2: LATENCY=5
    dm_bytelane #(.ADDR_WIDTH(12), .LATENCY(1)) u_l1 (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_addr(addr),
        .i_size(size), .i_uns(uns), .i_din(din), .o_dout(dout[0]),
        .o_ack(ack[0]), .o_err(err[0]), .o_busy(busy[0]), .o_state(state[0])
    );
    dm_bytelane #(.ADDR_WIDTH(12), .LATENCY(0)) u_l0 (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_addr(addr),
        .i_size(size), .i_uns(uns), .i_din(din), .o_dout(dout[1]),
        .o_ack(ack[1]), .o_err(err[1]), .o_busy(busy[1]), .o_state(state[1])
    );
    dm_bytelane #(.ADDR_WIDTH(12), .LATENCY(5)) u_l5 (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_addr(addr),
        .i_size(size), .i_uns(uns), .i_din(din), .o_dout(dout[2]),
        .o_ack(ack[2]), .o_err(err[2]), .o_busy(busy[2]), .o_state(state[2])
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // One access on the LATENCY=1 instance; checks ack timing, err and dout.
    task automatic acc(input string tag, input logic w, input logic [11:0] a,
                       input logic [1:0] sz, input logic u, input logic [31:0] d,
                       input logic exp_err, input logic [31:0] exp_dout);
        int cyc;
        @(negedge clk);
        we = w; addr = a; size = sz; uns = u; din = d; req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        cyc = 1;
        while (!ack[0] && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_lat"}, 32'(cyc), 32'd3);
        check({tag, "_err"}, {31'd0, err[0]}, {31'd0, exp_err});
        check({tag, "_dout"}, dout[0], exp_dout);
        @(negedge clk);
        check({tag, "_ackpulse"}, {31'd0, ack[0]}, 32'd0);
        check({tag, "_idle"}, {31'd0, busy[0]}, 32'd0);
    endtask

    initial begin
        int lat [3];
        lat[0] = 1; lat[1] = 0; lat[2] = 5;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_dout", dout[0], 32'd0);
        check("rst_ack", {31'd0, ack[0]}, 32'd0);
        check("rst_err", {31'd0, err[0]}, 32'd0);
        check("rst_busy", {31'd0, busy[0]}, 32'd0);

        acc("sw_004",   1'b1, 12'h004, 2'b10, 1'b0, 32'h12345678, 1'b0, 32'h00000000);
        acc("lw_004",   1'b0, 12'h004, 2'b10, 1'b0, 32'h0,        1'b0, 32'h12345678);
        acc("sw_008",   1'b1, 12'h008, 2'b10, 1'b0, 32'h11223344, 1'b0, 32'h12345678);
        acc("sb_00a",   1'b1, 12'h00A, 2'b00, 1'b0, 32'hFFFFFFAA, 1'b0, 32'h12345678);
        acc("sh_008",   1'b1, 12'h008, 2'b01, 1'b0, 32'h0000BEEF, 1'b0, 32'h12345678);
        acc("lw_008",   1'b0, 12'h008, 2'b10, 1'b0, 32'h0,        1'b0, 32'h11AABEEF);
        acc("sw_00c",   1'b1, 12'h00C, 2'b10, 1'b0, 32'h0080FF7F, 1'b0, 32'h11AABEEF);
        acc("lb_00d",   1'b0, 12'h00D, 2'b00, 1'b0, 32'h0,        1'b0, 32'hFFFFFFFF);
        acc("lbu_00d",  1'b0, 12'h00D, 2'b00, 1'b1, 32'h0,        1'b0, 32'h000000FF);
        acc("lh_00e",   1'b0, 12'h00E, 2'b01, 1'b0, 32'h0,        1'b0, 32'h00000080);
        acc("lh_00c",   1'b0, 12'h00C, 2'b01, 1'b0, 32'h0,        1'b0, 32'hFFFFFF7F);
        acc("lhu_00c",  1'b0, 12'h00C, 2'b01, 1'b1, 32'h0,        1'b0, 32'h0000FF7F);
        acc("lb_00e",   1'b0, 12'h00E, 2'b00, 1'b0, 32'h0,        1'b0, 32'hFFFFFF80);
        acc("sw_000",   1'b1, 12'h000, 2'b10, 1'b0, 32'hA5A5A5A5, 1'b0, 32'hFFFFFF80);
        acc("lw_006",   1'b0, 12'h006, 2'b10, 1'b0, 32'h0,        1'b1, 32'hFFFFFF80);
        acc("sh_003",   1'b1, 12'h003, 2'b01, 1'b0, 32'h0000FFFF, 1'b1, 32'hFFFFFF80);
        acc("st_sz11",  1'b1, 12'h000, 2'b11, 1'b0, 32'h00000000, 1'b1, 32'hFFFFFF80);
        acc("ld_sz11",  1'b0, 12'h000, 2'b11, 1'b0, 32'h0,        1'b1, 32'hFFFFFF80);
        acc("lw_000",   1'b0, 12'h000, 2'b10, 1'b0, 32'h0,        1'b0, 32'hA5A5A5A5);
        acc("lw_004b",  1'b0, 12'h004, 2'b10, 1'b0, 32'h0,        1'b0, 32'h12345678);

        acc("sw_010",   1'b1, 12'h010, 2'b10, 1'b0, 32'h0BADF00D, 1'b0, 32'h12345678);
        acc("lw_010",   1'b0, 12'h010, 2'b10, 1'b0, 32'h0,        1'b0, 32'h0BADF00D);

        // Reset lands while the store sits in WAIT.
        @(negedge clk);
        we = 1'b1; addr = 12'h010; size = 2'b10; uns = 1'b0; din = 32'hDEADBEEF; req = 1'b1;
        @(posedge clk);
        #2;
        check("mid_wait", {30'd0, state[0]}, 32'd1);
        rst = 1'b1;
        #1;
        check("arst_dout", dout[0], 32'd0);
        check("arst_ack", {31'd0, ack[0]}, 32'd0);
        check("arst_busy", {31'd0, busy[0]}, 32'd0);
        check("arst_busy5", {31'd0, busy[2]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req = 1'b0;
        acc("lw_010r",  1'b0, 12'h010, 2'b10, 1'b0, 32'h0,        1'b0, 32'h0BADF00D);

        // Handshake rate with req held high on all three instances.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        we = 1'b0; addr = 12'h000; size = 2'b10; uns = 1'b0; req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("sweep_pre_busy%0d", lat[i]), {31'd0, busy[i]}, 32'd0);
        end
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                int p;
                p = (k - 1) % (lat[i] + 3);
                check($sformatf("sweep_l%0d_k%0d_ack", lat[i], k), {31'd0, ack[i]},
                      (p == lat[i] + 1) ? 32'd1 : 32'd0);
                check($sformatf("sweep_l%0d_k%0d_busy", lat[i], k), {31'd0, busy[i]},
                      (p == lat[i] + 2) ? 32'd0 : 32'd1);
            end
        end
        req = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
